// File: rtl/fetch_unit_types_pkg.sv
// Types and constants for the fetch unit and its branch target buffer.
package fetch_unit_types_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bctr_t;

    // Tag and target are sized for the widest case; tags of deeper BTBs leave the top bits zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        bctr_t       ctr;
    } btb_entry_t;

    localparam bctr_t BTB_ALLOC_CTR = WT;
    localparam bctr_t BTB_RESET_CTR = WNT;

    function automatic bctr_t ctr_step(input bctr_t c, input logic taken);
        bctr_t r;
        r = c;
        if (taken) begin
            if (c != ST) r = bctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) r = bctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_control_unit_types_pkg.sv
// Shared types of the hazard control unit: the next-PC choice it hands to fetch.
package hazard_control_unit_types_pkg;

    typedef enum logic [2:0] {
        PCNPC    = 3'd0,
        PCBPC    = 3'd1,
        PCJPC    = 3'd2,
        PCPTA    = 3'd3,
        PRBPC    = 3'd4,
        PCERROR5 = 3'd5,
        PCERROR6 = 3'd6,
        PCERROR7 = 3'd7
    } pcselect_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup, one-cycle training.
module branch_target_buffer
    import fetch_unit_types_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] lookup_pc,
    output logic        hit_taken,
    output logic [31:0] hit_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t       entries_q [ENTRIES];
    btb_entry_t       entries_d [ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    btb_entry_t       lk_e;
    btb_entry_t       up_e;
    logic             unused_low_bits;

    function automatic logic [29:0] tag_of(input logic [31:0] a);
        return a[31:2] >> IDX_W;
    endfunction

    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    always_comb begin
        lk_idx     = lookup_pc[IDX_W+1:2];
        lk_e       = entries_q[lk_idx];
        hit_taken  = lk_e.valid && (lk_e.tag == tag_of(lookup_pc)) && lk_e.ctr[1];
        hit_target = {lk_e.target, 2'b00};
    end

    // A miss that resolved not-taken leaves the slot alone so it cannot evict a useful entry.
    always_comb begin
        entries_d = entries_q;
        up_idx    = upd_pc[IDX_W+1:2];
        up_e      = entries_q[up_idx];
        if (upd_en) begin
            if (up_e.valid && (up_e.tag == tag_of(upd_pc))) begin
                entries_d[up_idx].ctr = ctr_step(up_e.ctr, upd_taken);
                if (upd_taken) entries_d[up_idx].target = upd_target[31:2];
            end else if (upd_taken) begin
                entries_d[up_idx] = '{valid: 1'b1, tag: tag_of(upd_pc),
                                      target: upd_target[31:2], ctr: BTB_ALLOC_CTR};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_RESET_CTR};
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-side PC register: applies the hazard unit's PC choice and hosts the branch target buffer.
module pc_fetch_unit
    import hazard_control_unit_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT     = 32'h00000000,
    parameter int          BTB_ENTRIES = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  pcselect,
    input  logic        pcen,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rbpc,
    input  logic        bupdate,
    input  logic [31:0] bupd_pc,
    input  logic        bupd_taken,
    input  logic [31:0] bupd_target,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pcsel_err
);

    pcselect_t   sel;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        err_q;
    logic        err_d;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        unused_low_bits;

    branch_target_buffer #(
        .ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .CLK       (CLK),
        .RST       (RST),
        .lookup_pc (pc_q),
        .hit_taken (btb_taken),
        .hit_target(btb_target),
        .upd_en    (bupdate),
        .upd_pc    (bupd_pc),
        .upd_taken (bupd_taken),
        .upd_target(bupd_target)
    );

    assign sel             = pcselect_t'(pcselect);
    assign unused_low_bits = ^{bpc[1:0], jpc[1:0], rbpc[1:0]};

    // Redirects flush and so ignore pcen; only the sequential choices honour a stall.
    always_comb begin
        npc         = pc_q + 32'd4;
        pred_target = btb_taken ? btb_target : npc;
        pc_d        = pc_q;
        err_d       = err_q;
        case (sel)
            PCBPC:   pc_d = {bpc[31:2], 2'b00};
            PCJPC:   pc_d = {jpc[31:2], 2'b00};
            PRBPC:   pc_d = {rbpc[31:2], 2'b00};
            PCNPC:   if (pcen) pc_d = {npc[31:2], 2'b00};
            PCPTA:   if (pcen) pc_d = {pred_target[31:2], 2'b00};
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q  <= PC_INIT;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc         = pc_q;
    assign pred_taken = btb_taken;
    assign pcsel_err  = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_fetch_unit;
    import hazard_control_unit_types_pkg::*;

    localparam int          NENT    = 8;
    localparam logic [31:0] PC_INIT = 32'h00000000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  pcselect;
    logic        pcen;
    logic [31:0] bpc, jpc, rbpc;
    logic        bupdate;
    logic [31:0] bupd_pc;
    logic        bupd_taken;
    logic [31:0] bupd_target;
    logic [31:0] pc, npc, pred_target;
    logic        pred_taken, pcsel_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    bit          m_err;
    bit          m_valid [NENT];
    logic [31:0] m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    bit          model_ok = 0;

    always #5 CLK = ~CLK;

    pc_fetch_unit #(
        .PC_INIT    (PC_INIT),
        .BTB_ENTRIES(NENT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pcselect   (pcselect),
        .pcen       (pcen),
        .bpc        (bpc),
        .jpc        (jpc),
        .rbpc       (rbpc),
        .bupdate    (bupdate),
        .bupd_pc    (bupd_pc),
        .bupd_taken (bupd_taken),
        .bupd_target(bupd_target),
        .pc         (pc),
        .npc        (npc),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .pcsel_err  (pcsel_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelLookup(input logic [31:0] p, output bit t, output logic [31:0] tg);
        int i;
        i  = int'((p >> 2) % NENT);
        tg = p + 32'd4;
        t  = m_valid[i] && (m_tag[i] == p / (4 * NENT)) && (m_ctr[i] >= 2);
        if (t) tg = m_tgt[i];
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        logic [31:0] nx;
        logic [31:0] ptg;
        bit          pt;
        int          i;
        logic [31:0] tg;
        if (RST) begin
            m_pc  = PC_INIT;
            m_err = 0;
            for (int k = 0; k < NENT; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
                m_tag[k]   = 0;
                m_tgt[k]   = 0;
            end
            model_ok = 1;
        end else begin
            nx = m_pc + 32'd4;
            modelLookup(m_pc, pt, ptg);
            case (pcselect)
                PCBPC:   m_pc = bpc & ~32'd3;
                PCJPC:   m_pc = jpc & ~32'd3;
                PRBPC:   m_pc = rbpc & ~32'd3;
                PCNPC:   if (pcen) m_pc = nx & ~32'd3;
                PCPTA:   if (pcen) m_pc = ptg & ~32'd3;
                default: m_err = 1;
            endcase
            if (bupdate) begin
                i  = int'((bupd_pc >> 2) % NENT);
                tg = bupd_pc / (4 * NENT);
                if (m_valid[i] && m_tag[i] == tg) begin
                    if (bupd_taken) begin
                        if (m_ctr[i] < 3) m_ctr[i]++;
                        m_tgt[i] = bupd_target & ~32'd3;
                    end else if (m_ctr[i] > 0) begin
                        m_ctr[i]--;
                    end
                end else if (bupd_taken) begin
                    m_valid[i] = 1;
                    m_tag[i]   = tg;
                    m_tgt[i]   = bupd_target & ~32'd3;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        bit          t;
        logic [31:0] tg;
        if (model_ok) begin
            modelLookup(m_pc, t, tg);
            checkOutput("pc", pc, m_pc);
            checkOutput("npc", npc, m_pc + 32'd4);
            checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, t});
            checkOutput("pred_target", pred_target, tg);
            checkOutput("pcsel_err", {31'd0, pcsel_err}, {31'd0, m_err});
        end
    end

    task automatic driveInputs(input logic r, input logic [2:0] sel, input logic en,
                               input logic [31:0] b, input logic [31:0] j, input logic [31:0] rb,
                               input logic bu, input logic [31:0] bp, input logic bt,
                               input logic [31:0] btg);
        RST         = r;
        pcselect    = sel;
        pcen        = en;
        bpc         = b;
        jpc         = j;
        rbpc        = rb;
        bupdate     = bu;
        bupd_pc     = bp;
        bupd_taken  = bt;
        bupd_target = btg;
    endtask

    task automatic stepClock();
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] sel, input logic en,
                                 input logic [31:0] b, input logic [31:0] j, input logic [31:0] rb,
                                 input logic bu, input logic [31:0] bp, input logic bt,
                                 input logic [31:0] btg);
        driveInputs(r, sel, en, b, j, rb, bu, bp, bt, btg);
        stepClock();
    endtask

    task automatic go(input logic [2:0] sel, input logic en);
        applyStimulus(1'b0, sel, en, 32'hDEAD0100, 32'hBEEF0200, 32'hCAFE0300,
                      1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // The unselected redirect inputs carry a different address so a wrong mux leg shows up.
    task automatic redirectTo(input logic [2:0] sel, input logic [31:0] a);
        logic [31:0] other;
        other = a ^ 32'h00001000;
        applyStimulus(1'b0, sel, 1'b0,
                      (sel == PCBPC) ? a : other,
                      (sel == PCJPC) ? a : other,
                      (sel == PRBPC) ? a : other,
                      1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] p, input logic t, input logic [31:0] tgt);
        applyStimulus(1'b0, PCNPC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, p, t, tgt);
    endtask

    task automatic doReset(input logic bu, input logic [31:0] bp, input logic bt, input logic [31:0] btg);
        applyStimulus(1'b1, PCNPC, 1'b1, 32'h0, 32'h0, 32'h0, bu, bp, bt, btg);
    endtask

    function automatic logic [31:0] pickAddr();
        logic [31:0] pool [8];
        pool = '{32'h40, 32'h60, 32'h44, 32'h80, 32'h100, 32'h20, 32'h3C, 32'hFFFFFFFC};
        if ($urandom_range(0, 7) == 0) return $urandom();
        return pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [2:0] rs;
        doReset(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset npc", npc, 32'h4);
        checkOutput("reset pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("reset pred_target", pred_target, 32'h4);
        checkOutput("reset pcsel_err", {31'd0, pcsel_err}, 32'd0);

        go(PCNPC, 1'b1);
        checkOutput("seq pc 1", pc, 32'h4);
        go(PCNPC, 1'b1);
        go(PCNPC, 1'b1);
        checkOutput("seq pc 3", pc, 32'hC);
        go(PCNPC, 1'b0);
        go(PCPTA, 1'b0);
        checkOutput("stall hold", pc, 32'hC);

        redirectTo(PCJPC, 32'h00400013);
        checkOutput("jump masked", pc, 32'h00400010);
        redirectTo(PCBPC, 32'h100);
        checkOutput("branch redirect", pc, 32'h100);
        redirectTo(PRBPC, 32'h204);
        checkOutput("recovery redirect", pc, 32'h204);

        train(32'h40, 1'b1, 32'h80);
        redirectTo(PCJPC, 32'h40);
        checkOutput("alloc pred_taken", {31'd0, pred_taken}, 32'd1);
        checkOutput("alloc pred_target", pred_target, 32'h80);
        go(PCPTA, 1'b1);
        checkOutput("follow PTA", pc, 32'h80);

        train(32'h40, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        redirectTo(PCJPC, 32'h40);
        checkOutput("SNT pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("SNT pred_target", pred_target, 32'h44);
        for (int k = 0; k < 4; k++) train(32'h40, 1'b1, 32'h88);
        checkOutput("ST pred_target", pred_target, 32'h88);
        train(32'h40, 1'b0, 32'h0);
        checkOutput("saturated then NT", {31'd0, pred_taken}, 32'd1);
        train(32'h40, 1'b0, 32'h0);
        checkOutput("WNT after two NT", {31'd0, pred_taken}, 32'd0);

        train(32'h40, 1'b1, 32'h88);
        train(32'h60, 1'b1, 32'h200);
        checkOutput("evicted pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("evicted pred_target", pred_target, 32'h44);
        redirectTo(PCJPC, 32'h60);
        checkOutput("alias pred_target", pred_target, 32'h200);

        redirectTo(PCJPC, 32'h20);
        go(PCERROR6, 1'b1);
        checkOutput("error holds pc", pc, 32'h20);
        checkOutput("error flag set", {31'd0, pcsel_err}, 32'd1);
        go(PCNPC, 1'b1);
        checkOutput("advance after error", pc, 32'h24);
        checkOutput("error flag sticky", {31'd0, pcsel_err}, 32'd1);
        doReset(1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("error flag cleared", {31'd0, pcsel_err}, 32'd0);

        redirectTo(PCJPC, 32'hFFFFFFFC);
        checkOutput("npc wraps", npc, 32'h0);
        go(PCNPC, 1'b1);
        checkOutput("pc wraps", pc, 32'h0);

        redirectTo(PCJPC, 32'h40);
        driveInputs(1'b0, PCNPC, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h300);
        #1;
        checkOutput("same-cycle old view", {31'd0, pred_taken}, 32'd0);
        stepClock();
        checkOutput("next-cycle new view", pred_target, 32'h300);

        doReset(1'b1, 32'h40, 1'b1, 32'h300);
        redirectTo(PCJPC, 32'h40);
        checkOutput("reset beats update", {31'd0, pred_taken}, 32'd0);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) < 3) rs = 3'($urandom_range(5, 7));
            else rs = 3'($urandom_range(0, 4));
            applyStimulus(($urandom_range(0, 149) == 0), rs, ($urandom_range(0, 3) != 0),
                          pickAddr(), pickAddr(), pickAddr(),
                          ($urandom_range(0, 1) == 1), pickAddr(), ($urandom_range(0, 2) != 0),
                          pickAddr());
        end

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
